// File: rtl/bomba_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : bomba_pkg
//  Brief    : Shared types and constants for the multi-pump tank controller.
//  Revision : 1.0 - initial release
// ============================================================================
package bomba_pkg;

    typedef enum logic [1:0] {
        ESPERA  = 2'b00,
        LLENADO = 2'b01,
        ALARMA  = 2'b10
    } estado_t;

    localparam int CAUSA_ERR    = 0;
    localparam int CAUSA_SECO   = 1;
    localparam int CAUSA_TIEMPO = 2;
    localparam int CAUSA_BOMBA  = 3;

    // Filtered sensor patterns: tank low with cistern wet, and tank full
    localparam logic [2:0] c_f_llenar = 3'b001;
    localparam logic [2:0] c_f_lleno  = 3'b111;

endpackage : bomba_pkg
`default_nettype wire

// File: rtl/bomba_debounce.sv
`default_nettype none
// ============================================================================
//  Module   : bomba_debounce
//  Brief    : Single-bit debouncer; output follows input after DEB_CYCLES
//             consecutive differing samples.
//  Revision : 1.0 - initial release
// ============================================================================
module bomba_debounce #(
    parameter int   DEB_CYCLES = 16,
    parameter logic RST_VAL    = 1'b1
) (
    input  logic ck,
    input  logic rst_i,
    input  logic raw_i,
    output logic f_o
);

    localparam int              CW     = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0]   c_ult  = CW'(DEB_CYCLES - 1);

    logic [CW-1:0] r_cnt;
    logic          r_f;

    always_ff @(posedge ck) begin
        if (rst_i) begin
            r_cnt <= '0;
            r_f   <= RST_VAL;
        end else if (raw_i == r_f) begin
            r_cnt <= '0;
        end else if (r_cnt == c_ult) begin
            // This sample completes the run of differing samples
            r_f   <= raw_i;
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign f_o = r_f;

endmodule : bomba_debounce
`default_nettype wire

// File: rtl/bomba_multi.sv
`default_nettype none
// ============================================================================
//  Module   : bomba_multi
//  Brief    : Multi-pump tank controller: debounced sensors, round-robin pump
//             rotation with fault failover, run watchdog and latched alarms.
//  Revision : 1.0 - initial release
// ============================================================================
module bomba_multi
    import bomba_pkg::*;
#(
    parameter int N_PUMPS    = 2,
    parameter int DEB_CYCLES = 16,
    parameter int MAX_RUN    = 1024
) (
    input  logic               ck,
    input  logic               rst_i,
    input  logic [2:0]         sensores_i,
    input  logic [N_PUMPS-1:0] pump_fault_i,
    input  logic               ack_i,
    output logic [N_PUMPS-1:0] bomba_o,
    output logic               alarma_o,
    output logic [3:0]         causa_o,
    output logic [((N_PUMPS > 1) ? $clog2(N_PUMPS) : 1)-1:0] activa_o
);

    localparam int                 AW      = (N_PUMPS > 1) ? $clog2(N_PUMPS) : 1;
    localparam int                 TW      = $clog2(MAX_RUN);
    localparam logic [TW-1:0]      c_t_fin = TW'(MAX_RUN - 1);
    localparam logic [N_PUMPS-1:0] c_uno   = N_PUMPS'(1);

    // First healthy pump after cur, wrapping; cur itself is the last candidate
    function automatic logic [AW-1:0] next_healthy(input logic [AW-1:0]      cur,
                                                   input logic [N_PUMPS-1:0] h);
        logic [AW-1:0] res;
        logic [AW-1:0] cand;
        logic          found;
        res   = cur;
        found = 1'b0;
        for (int i = 1; i <= N_PUMPS; i++) begin
            cand = AW'((int'(cur) + i) % N_PUMPS);
            if (!found && h[cand]) begin
                res   = cand;
                found = 1'b1;
            end
        end
        return res;
    endfunction

    logic [2:0]         w_f;
    logic               w_err, w_dry, w_none, w_timeout, w_falla_act;
    logic [N_PUMPS-1:0] w_healthy;
    logic [AW-1:0]      w_sig;

    estado_t            r_state, w_state_nx;
    logic [AW-1:0]      r_activa, w_activa_nx;
    logic [3:0]         r_causa, w_causa_nx, w_causa_new;
    logic [TW-1:0]      r_timer, w_timer_nx;

    for (genvar g = 0; g < 3; g++) begin : g_deb
        bomba_debounce #(
            .DEB_CYCLES (DEB_CYCLES),
            .RST_VAL    (1'b1)
        ) u_deb (
            .ck    (ck),
            .rst_i (rst_i),
            .raw_i (sensores_i[g]),
            .f_o   (w_f[g])
        );
    end

    assign w_err       = w_f[2] & ~w_f[1];
    assign w_dry       = ~w_f[0];
    assign w_healthy   = ~pump_fault_i;
    assign w_none      = ~|w_healthy;
    assign w_timeout   = (r_timer == c_t_fin);
    assign w_falla_act = pump_fault_i[r_activa];
    assign w_sig       = next_healthy(r_activa, w_healthy);

    always_comb begin
        w_state_nx  = r_state;
        w_activa_nx = r_activa;
        w_causa_nx  = r_causa;
        w_timer_nx  = r_timer;
        w_causa_new = '0;
        w_causa_new[CAUSA_ERR]  = w_err;
        w_causa_new[CAUSA_SECO] = w_dry;

        case (r_state)
            ESPERA: begin
                // Missing pumps only matter once a fill is actually wanted
                w_causa_new[CAUSA_BOMBA] = (w_f == c_f_llenar) && w_none;
                if (|w_causa_new) begin
                    w_state_nx = ALARMA;
                    w_causa_nx = r_causa | w_causa_new;
                end else if (w_f == c_f_llenar) begin
                    w_state_nx  = LLENADO;
                    w_activa_nx = w_sig;
                    w_timer_nx  = '0;
                end
            end
            LLENADO: begin
                w_timer_nx = r_timer + 1'b1;
                w_causa_new[CAUSA_BOMBA]  = w_none;
                w_causa_new[CAUSA_TIEMPO] = w_timeout;
                if (|w_causa_new) begin
                    w_state_nx = ALARMA;
                    w_causa_nx = r_causa | w_causa_new;
                end else if (w_f == c_f_lleno) begin
                    w_state_nx = ESPERA;
                end else if (w_falla_act) begin
                    w_activa_nx = w_sig;
                end
            end
            ALARMA: begin
                w_causa_new[CAUSA_BOMBA] = w_none;
                if (ack_i && !(|w_causa_new)) begin
                    w_state_nx = ESPERA;
                    w_causa_nx = '0;
                end else begin
                    w_causa_nx = r_causa | w_causa_new;
                end
            end
            default: w_state_nx = ESPERA;
        endcase
    end

    always_ff @(posedge ck) begin
        if (rst_i) begin
            r_state  <= ESPERA;
            r_activa <= '0;
            r_causa  <= '0;
            r_timer  <= '0;
        end else begin
            r_state  <= w_state_nx;
            r_activa <= w_activa_nx;
            r_causa  <= w_causa_nx;
            r_timer  <= w_timer_nx;
        end
    end

    assign bomba_o  = (r_state == LLENADO) ? (c_uno << r_activa) : '0;
    assign alarma_o = (r_state == ALARMA);
    assign causa_o  = r_causa;
    assign activa_o = r_activa;

endmodule : bomba_multi
`default_nettype wire
